bidir_bus_peer: RTL

- Far-end responder for the shared 8-bit bidirectional parallel bus.
- The initiator owns direction (ext_dir) and strobe (ext_stb). This block answers with a 4-phase ack (ext_ack), captures write data from the bus and drives read data onto it.
- Per-bit IOBUFs sit inside the block; the fabric side is a ready/valid TX port and a pulsed RX port.
- Bus turnaround is guarded by programmable dead cycles.

---
 rtl/bidir_bus_peer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bidir_bus_peer.sv
`timescale 1ns / 1ps
// bidir_bus_peer
// Far-end responder on a shared bidirectional parallel bus. The initiator owns
// direction (ext_dir) and strobe (ext_stb); this block answers with a 4-phase
// acknowledge, captures write data from the bus and drives read data onto it.
// Bus turnaround is guarded by TURN_CYCLES dead cycles on every pad enable and
// release.
//
// Ports:
//   clk_100MHz  system clock
//   rst         asynchronous active-high reset (releases the bus immediately)
//   ext_stb     initiator strobe, 4-phase handshake
//   ext_dir     0: initiator writes to us, 1: initiator reads from us
//   ext_ack     handshake acknowledge (registered)
//   data_io     shared bus, one tri-state buffer per bit with a common enable
//   tx_data     word returned on the next read
//   tx_valid    tx_data is valid
//   tx_ready    one-cycle pulse, tx_data consumed
//   rx_data     last word written by the initiator
//   rx_valid    one-cycle pulse, rx_data updated
//   busy        FSM is not idle
module bidir_bus_peer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TURN_CYCLES = 4,  // >= 1
  parameter int unsigned SYNC_STAGES = 2   // >= 2
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  input  logic                  ext_stb,
  input  logic                  ext_dir,
  output logic                  ext_ack,
  inout  wire  [DATA_WIDTH-1:0] data_io,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int unsigned CntW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  // Counter runs TURN_CYCLES-1 down to 0, giving TURN_CYCLES cycles in a state.
  localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrCap,
    StRdWait,
    StRdTurnOn,
    StAck,
    StTurnOff
  } state_e;

  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    ack_q, ack_d;
  logic                    t_q, t_d;

  logic [SYNC_STAGES-1:0]  stb_sync_q, dir_sync_q;
  logic [DATA_WIDTH-1:0]   bus_sync_q [SYNC_STAGES];
  logic                    stb_prev_q;
  logic                    stb_s, dir_s, stb_rise;
  logic [DATA_WIDTH-1:0]   bus_s;
  logic [DATA_WIDTH-1:0]   bus_in;

  // Pad buffers: T (t_q) is shared, 1 releases the pad.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_iobuf
    assign data_io[i] = t_q ? 1'bz : out_q[i];
    assign bus_in[i]  = data_io[i];
  end

  // Input synchronizers and strobe edge detector.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      stb_sync_q <= '0;
      dir_sync_q <= '0;
      stb_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_sync_q[i] <= '0;
      end
    end else begin
      stb_sync_q    <= {stb_sync_q[SYNC_STAGES-2:0], ext_stb};
      dir_sync_q    <= {dir_sync_q[SYNC_STAGES-2:0], ext_dir};
      stb_prev_q    <= stb_s;
      bus_sync_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bus_sync_q[i] <= bus_sync_q[i-1];
      end
    end
  end

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign dir_s    = dir_sync_q[SYNC_STAGES-1];
  assign bus_s    = bus_sync_q[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_prev_q;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ack_d      = ack_q;
    tx_ready   = 1'b0;

    case (state_q)
      StIdle: begin
        if (stb_rise) begin
          dir_d   = dir_s;
          state_d = dir_s ? StRdWait : StWrCap;
        end
      end
      StWrCap: begin
        // rx_valid and rx_data are registered together so the pulse marks the
        // cycle in which rx_data already holds the new word.
        rx_data_d  = bus_s;
        rx_valid_d = 1'b1;
        ack_d      = 1'b1;
        state_d    = StAck;
      end
      StRdWait: begin
        if (!stb_s) begin
          state_d = StIdle;
        end else if (tx_valid) begin
          tx_ready = 1'b1;
          out_d    = tx_data;
          cnt_d    = TurnLoad;
          state_d  = StRdTurnOn;
        end
      end
      StRdTurnOn: begin
        if (!stb_s) begin
          cnt_d   = TurnLoad;
          state_d = StTurnOff;
        end else if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        if (!stb_s) begin
          ack_d = 1'b0;
          if (dir_q) begin
            cnt_d   = TurnLoad;
            state_d = StTurnOff;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StTurnOff: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Pads are driven only while settling or acknowledging a read; deriving T
    // from the next state keeps it registered and aligned with the transition.
    t_d = !((state_d == StRdTurnOn) || ((state_d == StAck) && dir_d));
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      out_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      t_q        <= 1'b1;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ack_q      <= ack_d;
      t_q        <= t_d;
    end
  end

  assign ext_ack  = ack_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle);

endmodule
